// File: rtl/debug_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debug_link_pkg                                            |
// | Purpose  : Shared constants and FSM state type for the debug serial  |
// |            link (transmitter and receiver).                          |
// | Contents : DEBUG_FRAME_BITS, DEBUG_MIN_GAP, debug_state_e            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package debug_link_pkg;

   localparam int DEBUG_FRAME_BITS = 40;
   // Receiver needs this many idle cycles after a frame to re-arm.
   localparam int DEBUG_MIN_GAP    = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      SHIFT   = 3'd2,
      GAP     = 3'd3,
      RECOVER = 3'd4
   } debug_state_e;

endpackage
`default_nettype wire

// File: rtl/debug_data_transmitter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debug_data_transmitter_if                                 |
// | Purpose  : Valid/ready word-push bus into the debug transmitter.     |
// | Signals  : tx_data  - 40-bit word to send                            |
// |            tx_valid - tx_data valid (producer)                       |
// |            tx_ready - transmitter can accept (consumer)              |
// | Modports : master (producer side), slave (transmitter side)          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface debug_data_transmitter_if;
   import debug_link_pkg::*;

   logic [DEBUG_FRAME_BITS-1:0] tx_data;
   logic                        tx_valid;
   logic                        tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/debug_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debug_word_fifo                                           |
// | Purpose  : Single-clock word FIFO, ready/valid push, strobe pop.     |
// | Ports    : debug_clk, reset (sync, active-high)                      |
// |            push_data_i/push_valid_i/push_ready_o - push handshake    |
// |            pop_i - pop strobe, pop_data_o - head word, empty_o       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module debug_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  wire logic             debug_clk,
   input  wire logic             reset,
   input  wire logic [WIDTH-1:0] push_data_i,
   input  wire logic             push_valid_i,
   output logic                  push_ready_o,
   input  wire logic             pop_i,
   output logic [WIDTH-1:0]      pop_data_o,
   output logic                  empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             ready_q;
   logic             do_push;
   logic             do_pop;

   // ready_q is the registered "not full", so a full FIFO refuses a push
   // even when a pop happens on the same edge.
   assign do_push = push_valid_i && ready_q;
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge debug_clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         ready_q <= (count_d != CW'(DEPTH));
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge debug_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o   = mem_q[rd_ptr_q];
   assign empty_o      = (count_q == '0);
   assign push_ready_o = ready_q;

endmodule
`default_nettype wire

// File: rtl/debug_data_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debug_data_transmitter                                    |
// | Purpose  : Serialises queued 40-bit debug words: a one-cycle         |
// |            data_start strobe, then 40 bits MSB-first on sout.        |
// | Ports    : debug_clk, reset (sync, active-high)                      |
// |            tx          - word push bus (slave modport)               |
// |            data_start  - frame start strobe                          |
// |            sout        - serial data                                 |
// |            busy        - FSM not idle or words queued                |
// |            frames_sent - completed frame count (wraps)               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module debug_data_transmitter
   import debug_link_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = DEBUG_MIN_GAP,
   parameter int CNT_W      = 16
) (
   input  wire logic               debug_clk,
   input  wire logic               reset,
   debug_data_transmitter_if.slave tx,
   output logic                    data_start,
   output logic                    sout,
   output logic                    busy,
   output logic [CNT_W-1:0]        frames_sent
);

   localparam int FB    = DEBUG_FRAME_BITS;
   localparam int GAP_W = $clog2(FB + GAP_CYCLES + 1);

   debug_state_e          state_q;
   debug_state_e          state_d;
   logic [5:0]            bit_cnt_q;
   logic [5:0]            bit_cnt_d;
   // Shared by GAP and RECOVER; sized for the longer RECOVER interval.
   logic [GAP_W-1:0]      gap_cnt_q;
   logic [GAP_W-1:0]      gap_cnt_d;
   logic [FB-1:0]         shreg_q;
   logic [FB-1:0]         shreg_d;
   logic                  data_start_q;
   logic                  sout_q;
   logic                  busy_q;
   logic [CNT_W-1:0]      frames_q;
   logic                  frame_done;

   logic                  fifo_pop;
   logic                  fifo_empty;
   logic [FB-1:0]         fifo_data;

   debug_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FB)
   ) u_fifo (
      .debug_clk    (debug_clk),
      .reset        (reset),
      .push_data_i  (tx.tx_data),
      .push_valid_i (tx.tx_valid),
      .push_ready_o (tx.tx_ready),
      .pop_i        (fifo_pop),
      .pop_data_o   (fifo_data),
      .empty_o      (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      shreg_d    = shreg_q;
      fifo_pop   = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shreg_d  = fifo_data;
               state_d  = START;
            end
         end
         START: begin
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            shreg_d = {shreg_q[FB-2:0], 1'b0};
            if (bit_cnt_q == 6'(FB - 1)) begin
               frame_done = 1'b1;
               gap_cnt_d  = '0;
               state_d    = GAP;
            end else begin
               bit_cnt_d = bit_cnt_q + 6'd1;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         RECOVER: begin
            // Hold the line low for a full frame plus gap so a receiver
            // caught mid-frame drains zeros and re-arms.
            if (gap_cnt_q == GAP_W'(FB + GAP_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            gap_cnt_d = '0;
            state_d   = RECOVER;
         end
      endcase
   end

   // Outputs are registered from the current state, so they lag the
   // state by one cycle (strobe appears the cycle after START is entered).
   always_ff @(posedge debug_clk) begin
      if (reset) begin
         state_q      <= RECOVER;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         shreg_q      <= '0;
         data_start_q <= 1'b0;
         sout_q       <= 1'b0;
         busy_q       <= 1'b1;
         frames_q     <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         shreg_q      <= shreg_d;
         data_start_q <= (state_q == START);
         sout_q       <= (state_q == SHIFT) && shreg_q[FB-1];
         busy_q       <= (state_q != IDLE) || !fifo_empty;
         if (frame_done) frames_q <= frames_q + CNT_W'(1);
      end
   end

   assign data_start  = data_start_q;
   assign sout        = sout_q;
   assign busy        = busy_q;
   assign frames_sent = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_data_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_debug_data_transmitter                                 |
// | Purpose  : Self-checking bench for debug_data_transmitter: frame     |
// |            timeline reference model, serial receiver model, and      |
// |            directed plus random push traffic.                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_debug_data_transmitter;
   import debug_link_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int GAP_CYCLES = 3;
   localparam int CNT_W      = 2;
   localparam int FB         = DEBUG_FRAME_BITS;
   localparam int FRAME_SPAN = 1 + FB + GAP_CYCLES;   // START+SHIFT+GAP
   localparam int RECOV_LEN  = FB + GAP_CYCLES;

   logic             debug_clk = 1'b0;
   logic             reset     = 1'b1;
   logic             data_start;
   logic             sout;
   logic             busy;
   logic [CNT_W-1:0] frames_sent;

   debug_data_transmitter_if tx_if();

   debug_data_transmitter #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .GAP_CYCLES (GAP_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .debug_clk   (debug_clk),
      .reset       (reset),
      .tx          (tx_if),
      .data_start  (data_start),
      .sout        (sout),
      .busy        (busy),
      .frames_sent (frames_sent)
   );

   always #5 debug_clk = ~debug_clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out", name);
   endtask

   // ---------------- reference model (frame timeline) ----------------
   // m_k = cycles since the word was popped (0 = START), -1 = no frame.
   logic [FB-1:0]    m_q[$];
   logic [FB-1:0]    exp_rx[$];
   logic [FB-1:0]    m_word = '0;
   int               m_k    = -1;
   int               m_rec  = 0;
   int               cyc    = 0;
   logic             e_ds = 1'b0, e_sout = 1'b0, e_ready = 1'b0, e_busy = 1'b1;
   logic [CNT_W-1:0] e_frames = '0;

   task automatic model_step();
      bit pre_idle;
      bit pre_nonempty;
      cyc++;
      if (reset) begin
         m_q.delete();
         m_k      = -1;
         m_rec    = RECOV_LEN;
         e_ds     = 1'b0;
         e_sout   = 1'b0;
         e_ready  = 1'b0;
         e_busy   = 1'b1;
         e_frames = '0;
      end else begin
         pre_idle     = (m_rec == 0) && (m_k < 0);
         pre_nonempty = (m_q.size() > 0);
         e_busy       = !pre_idle || pre_nonempty;
         if (m_rec > 0) begin
            m_rec--;
         end else if (m_k >= 0) begin
            m_k++;
            if (m_k == FRAME_SPAN) m_k = -1;
         end else if (pre_nonempty) begin
            m_word = m_q.pop_front();
            m_k    = 0;
         end
         if (tx_if.tx_valid && e_ready) m_q.push_back(tx_if.tx_data);
         e_ds   = (m_k == 1);
         e_sout = (m_k >= 2 && m_k <= FB + 1) ? m_word[FB + 1 - m_k] : 1'b0;
         if (m_k == FB + 1) begin
            e_frames = e_frames + 1'b1;
            exp_rx.push_back(m_word);
         end
         e_ready = (m_q.size() < FIFO_DEPTH);
      end
   endtask

   initial forever begin
      @(posedge debug_clk);
      model_step();
   end

   // ---------------- compare process + receiver model ----------------
   logic [FB-1:0]    rx_log[$];
   int               ds_cyc[$];
   logic [CNT_W-1:0] fr_log[$];
   int               fr_cyc = 0;

   initial begin
      logic             prev_ds = 1'b0;
      logic [CNT_W-1:0] prev_fr = '0;
      logic [FB-1:0]    cap_w   = '0;
      int               cap_n   = 0;
      forever begin
         @(negedge debug_clk);
         check("data_start", data_start, e_ds);
         check("sout", sout, e_sout);
         check("tx_ready", tx_if.tx_ready, e_ready);
         check("busy", busy, e_busy);
         check("frames_sent", frames_sent, e_frames);
         check("ds_twice", prev_ds && data_start, 1'b0);
         check("ds_and_sout", data_start && sout, 1'b0);
         prev_ds = data_start;
         if (data_start) ds_cyc.push_back(cyc);
         if (frames_sent !== prev_fr) begin
            fr_log.push_back(frames_sent);
            fr_cyc = cyc;
         end
         prev_fr = frames_sent;
         if (reset) begin
            cap_n = 0;
         end else if (cap_n > 0) begin
            cap_w = {cap_w[FB-2:0], sout};
            cap_n--;
            if (cap_n == 0) begin
               rx_log.push_back(cap_w);
               if (exp_rx.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rx_word: got %0h expected none", cap_w);
               end else begin
                  check("rx_word", cap_w, exp_rx.pop_front());
               end
            end
         end
         if (data_start && !reset) cap_n = FB;
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_word(input logic [FB-1:0] w, output int waited);
      waited = 0;
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = w;
      while (!tx_if.tx_ready && waited < 300) begin
         @(negedge debug_clk);
         waited++;
      end
      if (waited >= 300) timeout_fail("push_word");
      @(negedge debug_clk);
      tx_if.tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge debug_clk);
         n++;
      end
      if (n >= limit) timeout_fail("wait_idle");
   endtask

   function automatic logic [FB-1:0] rand_word();
      return {8'($urandom), 32'($urandom)};
   endfunction

   initial begin
      logic [FB-1:0] w[6];
      logic [FB-1:0] w_r;
      logic [CNT_W-1:0] fr_expect[5];
      int n;
      int lat;
      int acc;
      bit stalled;
      bit acc_next;

      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = '0;
      @(negedge debug_clk);
      check("rst_data_start", data_start, 1'b0);
      check("rst_sout", sout, 1'b0);
      check("rst_tx_ready", tx_if.tx_ready, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_frames", frames_sent, 2'd0);
      @(negedge debug_clk);
      reset = 1'b0;
      wait_idle(200);

      // Single word: latency and captured value.
      push_word(40'hA5_F0AA_AA_A9, n);
      check("single_no_wait", n, 0);
      lat = 1;
      while (!data_start && lat < 10) begin
         @(negedge debug_clk);
         lat++;
      end
      check("first_latency", lat, 3);
      wait_idle(200);
      check("single_rx_count", rx_log.size(), 1);
      if (rx_log.size() > 0) check("single_rx_word", rx_log[rx_log.size()-1], 40'hA5F0AAAAA9);
      check("single_frames", frames_sent, 2'd1);

      // Burst of 6 words into a 4-deep FIFO.
      rx_log.delete();
      ds_cyc.delete();
      acc = 0;
      stalled = 0;
      for (int i = 0; i < 6; i++) begin
         w[i] = rand_word();
         push_word(w[i], n);
         if (n == 0 && !stalled) acc++;
         else stalled = 1;
      end
      check("burst_accepts", acc, 5);
      wait_idle(600);
      check("burst_rx_count", rx_log.size(), 6);
      for (int i = 0; i < 6 && i < rx_log.size(); i++) check("burst_rx_order", rx_log[i], w[i]);
      check("burst_ds_count", ds_cyc.size(), 6);
      for (int i = 1; i < ds_cyc.size(); i++) check("burst_ds_period", ds_cyc[i] - ds_cyc[i-1], 45);

      // Random traffic with random gaps.
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge debug_clk);
         push_word(rand_word(), n);
      end
      wait_idle(1200);

      // Reset mid-frame.
      push_word(rand_word(), n);
      lat = 0;
      while (!data_start && lat < 10) begin
         @(negedge debug_clk);
         lat++;
      end
      if (lat >= 10) timeout_fail("midframe_start");
      repeat (20) @(negedge debug_clk);
      reset = 1'b1;
      @(negedge debug_clk);
      check("mid_rst_data_start", data_start, 1'b0);
      check("mid_rst_sout", sout, 1'b0);
      check("mid_rst_busy", busy, 1'b1);
      check("mid_rst_tx_ready", tx_if.tx_ready, 1'b0);
      @(negedge debug_clk);
      w_r = rand_word();
      reset = 1'b0;
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = w_r;
      fr_log.delete();
      rx_log.delete();
      acc_next = 0;
      for (int i = 0; i < RECOV_LEN; i++) begin
         @(negedge debug_clk);
         if (acc_next) begin
            tx_if.tx_valid = 1'b0;
            acc_next = 0;
         end
         if (tx_if.tx_valid && tx_if.tx_ready) acc_next = 1;
         check("recover_busy", busy, 1'b1);
      end
      if (acc_next) @(negedge debug_clk);
      tx_if.tx_valid = 1'b0;

      // Four more frames: counter wraps at CNT_W=2.
      for (int i = 0; i < 4; i++) push_word(rand_word(), n);
      wait_idle(600);
      check("busy_fall_delay", cyc - fr_cyc, 1 + GAP_CYCLES);
      if (rx_log.size() > 0) check("recover_rx_word", rx_log[0], w_r);
      fr_expect = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      check("wrap_log_len", fr_log.size(), 5);
      for (int i = 0; i < 5 && i < fr_log.size(); i++) check("wrap_value", fr_log[i], fr_expect[i]);
      check("exp_rx_drained", exp_rx.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
